// File: rtl/mfm_sync_pkg.sv
// Shared types and constants for the MFM sync-mark acquisition sequencer.
package mfm_sync_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HUNT    = 3'd1,
      ST_CHAIN   = 3'd2,
      ST_FOUND   = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_e;

   localparam int CELLS_PER_MARK = 16;
   localparam int CELL_W         = 5;

endpackage

// File: rtl/async_edge_sync.sv
// Two-flop synchroniser for an asynchronous level, followed by a one-cycle
// rising-edge pulse taken from the synchronised value.
module async_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic rise_o
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = async_i;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   // NOTE: non-blocking updates so each flop takes its neighbour's old value
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/mfm_sync_sequencer.sv
// Hunts for a chain of sync marks spaced exactly one 16-bitcell word apart,
// reporting success or an index-pulse timeout.
module mfm_sync_sequencer
   import mfm_sync_pkg::*;
#(
   parameter int MARK_W  = 3,
   parameter int INDEX_W = 8
) (
   input  logic               CLK_PLL32MHZ,
   input  logic               RESET_N,
   input  logic               START,
   input  logic               ABORT,
   input  logic [MARK_W-1:0]  REQ_MARKS,
   input  logic [INDEX_W-1:0] INDEX_LIMIT,
   input  logic               BITCELL_STB,
   input  logic               SYNC_DET,
   input  logic               INDEX_IN,
   output logic               BUSY,
   output logic               MATCHED,
   output logic               DONE,
   output logic               TIMEOUT,
   output logic [MARK_W-1:0]  MARK_COUNT
);

   localparam logic [CELL_W-1:0] CELL_MARK = CELL_W'(CELLS_PER_MARK);
   localparam logic [MARK_W-1:0] ONE_MARK  = MARK_W'(1);

   state_e               state_q, state_d;
   logic [MARK_W-1:0]    req_q, req_d;
   logic [INDEX_W-1:0]   lim_q, lim_d;
   logic [MARK_W-1:0]    mark_q, mark_d;
   logic [CELL_W-1:0]    cell_q, cell_d;
   logic [INDEX_W-1:0]   idx_q, idx_d;
   logic                 matched_q, matched_d;

   logic                 sync_edge;
   logic                 index_edge;
   logic [CELL_W-1:0]    cell_eff;
   logic [MARK_W-1:0]    mark_inc;
   logic [INDEX_W-1:0]   idx_inc;
   logic                 idx_hit;
   logic                 spaced;
   logic                 chain_done;

   async_edge_sync u_sync_det (
      .clk     (CLK_PLL32MHZ),
      .rst_n   (RESET_N),
      .async_i (SYNC_DET),
      .rise_o  (sync_edge)
   );

   async_edge_sync u_index (
      .clk     (CLK_PLL32MHZ),
      .rst_n   (RESET_N),
      .async_i (INDEX_IN),
      .rise_o  (index_edge)
   );

   // A strobe landing in the edge cycle is counted before the spacing test.
   assign cell_eff   = cell_q + CELL_W'(BITCELL_STB);
   assign spaced     = (cell_eff == CELL_MARK);
   assign mark_inc   = mark_q + ONE_MARK;
   assign chain_done = (mark_inc >= req_q);
   assign idx_inc    = (idx_q == '1) ? idx_q : idx_q + INDEX_W'(1);
   assign idx_hit    = index_edge && (lim_q != '0) && (idx_inc == lim_q);

   // NOTE: every signal gets a default first so no latch is inferred
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      lim_d     = lim_q;
      mark_d    = mark_q;
      cell_d    = cell_q;
      idx_d     = idx_q;
      matched_d = 1'b0;

      if (ABORT) begin
         state_d = ST_IDLE;
         mark_d  = '0;
         cell_d  = '0;
         idx_d   = '0;
      end else if (START) begin
         state_d = ST_HUNT;
         req_d   = (REQ_MARKS == '0) ? ONE_MARK : REQ_MARKS;
         lim_d   = INDEX_LIMIT;
         mark_d  = '0;
         cell_d  = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               mark_d = '0;
               cell_d = '0;
               idx_d  = '0;
            end
            ST_HUNT: begin
               if (index_edge) idx_d = idx_inc;
               if (sync_edge) begin
                  mark_d = ONE_MARK;
                  cell_d = '0;
               end
               if (sync_edge && req_q == ONE_MARK) begin
                  state_d   = ST_FOUND;
                  matched_d = 1'b1;
               end else if (idx_hit) begin
                  state_d = ST_TIMEOUT;
               end else if (sync_edge) begin
                  state_d = ST_CHAIN;
               end
            end
            ST_CHAIN: begin
               if (index_edge) idx_d = idx_inc;
               cell_d = cell_eff;
               if (sync_edge) begin
                  cell_d = '0;
                  if (!spaced)         mark_d = ONE_MARK;
                  else if (chain_done) mark_d = req_q;
                  else                 mark_d = mark_inc;
               end
               // A completed chain beats a same-cycle timeout.
               if (sync_edge && spaced && chain_done) begin
                  state_d   = ST_FOUND;
                  matched_d = 1'b1;
               end else if (idx_hit) begin
                  state_d = ST_TIMEOUT;
               end else if (!sync_edge && cell_eff > CELL_MARK) begin
                  state_d = ST_HUNT;
                  mark_d  = '0;
                  cell_d  = '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK_PLL32MHZ) begin
      if (!RESET_N) begin
         state_q   <= ST_IDLE;
         req_q     <= '0;
         lim_q     <= '0;
         mark_q    <= '0;
         cell_q    <= '0;
         idx_q     <= '0;
         matched_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         lim_q     <= lim_d;
         mark_q    <= mark_d;
         cell_q    <= cell_d;
         idx_q     <= idx_d;
         matched_q <= matched_d;
      end
   end

   assign BUSY       = (state_q == ST_HUNT) || (state_q == ST_CHAIN);
   assign MATCHED    = matched_q;
   assign DONE       = (state_q == ST_FOUND);
   assign TIMEOUT    = (state_q == ST_TIMEOUT);
   assign MARK_COUNT = mark_q;

endmodule
